// File: rtl/mem_arbiter.sv
// Two-port RAM arbiter: CPU has priority, a starvation counter guarantees DMA a slot.
// Every access runs IDLE -> ADDR -> DATA -> DONE with all RAM-side signals registered.
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_we,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_ack,
  input  logic                  i_dma_req,
  input  logic                  i_dma_we,
  input  logic [ADDR_WIDTH-1:0] i_dma_addr,
  input  logic [DATA_WIDTH-1:0] i_dma_wdata,
  output logic [DATA_WIDTH-1:0] o_dma_rdata,
  output logic                  o_dma_ack,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_wdata,
  output logic                  o_mem_we,
  output logic                  o_mem_oe,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic                  o_grant_dma,
  output logic                  o_busy
);

  typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_e;

  localparam logic [3:0] StarveLimit = 4'(STARVE_LIMIT);

  state_e                r_state;
  logic                  r_we;
  logic [3:0]            r_starve;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic                  r_mem_we;
  logic                  r_mem_oe;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;
  logic [DATA_WIDTH-1:0] r_dma_rdata;
  logic                  r_cpu_ack;
  logic                  r_dma_ack;
  logic                  r_grant_dma;
  logic                  r_busy;

  logic                  w_sel_dma;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

  // DMA wins only when the CPU is idle or the DMA port has waited out its limit.
  assign w_sel_dma   = i_dma_req && (!i_cpu_req || (r_starve == StarveLimit));
  assign w_sel_we    = w_sel_dma ? i_dma_we    : i_cpu_we;
  assign w_sel_addr  = w_sel_dma ? i_dma_addr  : i_cpu_addr;
  assign w_sel_wdata = w_sel_dma ? i_dma_wdata : i_cpu_wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_we        <= 1'b0;
      r_starve    <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_we    <= 1'b0;
      r_mem_oe    <= 1'b0;
      r_cpu_rdata <= '0;
      r_dma_rdata <= '0;
      r_cpu_ack   <= 1'b0;
      r_dma_ack   <= 1'b0;
      r_grant_dma <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dma_ack <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!i_dma_req) r_starve <= '0;
          if (i_cpu_req || i_dma_req) begin
            r_grant_dma <= w_sel_dma;
            r_we        <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_oe    <= !w_sel_we;
            r_busy      <= 1'b1;
            r_state     <= StAddr;
            if (w_sel_dma) begin
              r_starve <= '0;
            end else if (i_dma_req && (r_starve < StarveLimit)) begin
              r_starve <= r_starve + 4'd1;
            end
          end
        end
        StAddr: begin
          r_mem_we <= r_we;
          r_state  <= StData;
        end
        StData: begin
          r_mem_we <= 1'b0;
          r_mem_oe <= 1'b0;
          if (!r_we) begin
            if (r_grant_dma) r_dma_rdata <= i_mem_rdata;
            else             r_cpu_rdata <= i_mem_rdata;
          end
          if (r_grant_dma) r_dma_ack <= 1'b1;
          else             r_cpu_ack <= 1'b1;
          r_state <= StDone;
        end
        StDone: begin
          r_busy  <= 1'b0;
          r_state <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_mem_we    = r_mem_we;
  assign o_mem_oe    = r_mem_oe;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_dma_rdata = r_dma_rdata;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_dma_ack   = r_dma_ack;
  assign o_grant_dma = r_grant_dma;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single accesses, arbitration order, starvation clear,
// mid-transaction reset and early request drop, against a small RAM model.
module tb_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we, dma_req, dma_we;
  logic [7:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
  logic [7:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
  logic       cpu_ack, dma_ack, mem_we, mem_oe, grant_dma, busy;

  logic [7:0] ram [256];
  logic       pre_we;
  logic [7:0] pre_addr, pre_data;

  int n_checks = 0;
  int n_errors = 0;

  int oe_cnt, we_cnt, ack_cnt, other_ack_cnt, ack_idx, grant_cnt, busy_cnt;
  logic [7:0] we_addr, we_data;
  bit owners [16];
  int n_acks, dbl_acks;

  mem_arbiter #(
    .ADDR_WIDTH  (8),
    .DATA_WIDTH  (8),
    .STARVE_LIMIT(3)
  ) u_dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cpu_req  (cpu_req),
    .i_cpu_we   (cpu_we),
    .i_cpu_addr (cpu_addr),
    .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata),
    .o_cpu_ack  (cpu_ack),
    .i_dma_req  (dma_req),
    .i_dma_we   (dma_we),
    .i_dma_addr (dma_addr),
    .i_dma_wdata(dma_wdata),
    .o_dma_rdata(dma_rdata),
    .o_dma_ack  (dma_ack),
    .o_mem_addr (mem_addr),
    .o_mem_wdata(mem_wdata),
    .o_mem_we   (mem_we),
    .o_mem_oe   (mem_oe),
    .i_mem_rdata(mem_rdata),
    .o_grant_dma(grant_dma),
    .o_busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)      ram[mem_addr] <= mem_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end
  assign mem_rdata = ram[mem_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pre_addr = a;
    pre_data = d;
    pre_we   = 1'b1;
    @(posedge clk);
    #1 pre_we = 1'b0;
  endtask

  // Issue one request and record per-cycle activity for 8 cycles after the granting edge.
  task automatic run_txn(input bit is_dma, input bit we, input logic [7:0] a,
                         input logic [7:0] d, input bit drop_early);
    if (is_dma) begin
      dma_we = we; dma_addr = a; dma_wdata = d; dma_req = 1'b1;
    end else begin
      cpu_we = we; cpu_addr = a; cpu_wdata = d; cpu_req = 1'b1;
    end
    @(posedge clk);
    oe_cnt = 0; we_cnt = 0; ack_cnt = 0; other_ack_cnt = 0;
    ack_idx = -1; grant_cnt = 0; busy_cnt = 0; we_addr = 8'h0; we_data = 8'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (mem_oe) oe_cnt++;
      if (mem_we) begin
        we_cnt++; we_addr = mem_addr; we_data = mem_wdata;
      end
      if (grant_dma && i < 3) grant_cnt++;
      if (busy) busy_cnt++;
      if (is_dma ? cpu_ack : dma_ack) other_ack_cnt++;
      if (is_dma ? dma_ack : cpu_ack) begin
        ack_cnt++;
        if (ack_idx < 0) ack_idx = i;
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
      end
      if (drop_early && i == 0) begin
        if (is_dma) dma_req = 1'b0; else cpu_req = 1'b0;
      end
    end
  endtask

  // Hold both requests; record the owner of each ack. Optionally drop dma_req for the
  // IDLE cycle that follows ack number drop_after.
  task automatic collect_acks(input int n, input int drop_after);
    bit prev;
    n_acks = 0; dbl_acks = 0; prev = 1'b0;
    cpu_req = 1'b1; dma_req = 1'b1;
    for (int c = 0; c < 200 && n_acks < n; c++) begin
      @(negedge clk);
      if (cpu_ack || dma_ack) begin
        if (prev || (cpu_ack && dma_ack)) dbl_acks++;
        owners[n_acks] = dma_ack;
        n_acks++;
        prev = 1'b1;
        if (n_acks == drop_after) begin
          dma_req = 1'b0;
          @(posedge clk);
          @(posedge clk);
          #1 dma_req = 1'b1;
          prev = 1'b0;
        end
      end else begin
        prev = 1'b0;
      end
    end
    cpu_req = 1'b0; dma_req = 1'b0;
    check_eq("ack_count_within_bound", n_acks, n);
    check_eq("single_cycle_acks", dbl_acks, 0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int ack_after_rst;
    bit exp_order_a [8];
    bit exp_order_b [7];
    exp_order_a = '{0, 0, 0, 1, 0, 0, 0, 1};
    exp_order_b = '{0, 0, 0, 0, 0, 0, 1};
    rst_n = 1'b0; pre_we = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    preload(8'h42, 8'hA5);
    preload(8'h10, 8'h00);
    preload(8'h20, 8'h00);
    preload(8'h55, 8'h00);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_mem_we", mem_we, 0);
    check_eq("rst_mem_oe", mem_oe, 0);
    check_eq("rst_acks", {cpu_ack, dma_ack}, 0);
    check_eq("rst_grant_dma", grant_dma, 0);
    check_eq("rst_mem_addr", mem_addr, 0);
    check_eq("rst_mem_wdata", mem_wdata, 0);
    check_eq("rst_rdata", {cpu_rdata, dma_rdata}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single CPU read
    run_txn(1'b0, 1'b0, 8'h42, 8'h00, 1'b0);
    check_eq("cpu_rd_oe_cycles", oe_cnt, 2);
    check_eq("cpu_rd_ack_idx", ack_idx, 2);
    check_eq("cpu_rd_ack_cnt", ack_cnt, 1);
    check_eq("cpu_rd_dma_ack", other_ack_cnt, 0);
    check_eq("cpu_rd_rdata", cpu_rdata, 8'hA5);
    check_eq("cpu_rd_no_we", we_cnt, 0);

    // Single DMA write
    run_txn(1'b1, 1'b1, 8'h10, 8'h3C, 1'b0);
    check_eq("dma_wr_we_cycles", we_cnt, 1);
    check_eq("dma_wr_addr", we_addr, 8'h10);
    check_eq("dma_wr_data", we_data, 8'h3C);
    check_eq("dma_wr_grant_cycles", grant_cnt, 3);
    check_eq("dma_wr_ack_idx", ack_idx, 2);
    check_eq("dma_wr_cpu_ack", other_ack_cnt, 0);
    check_eq("dma_wr_no_oe", oe_cnt, 0);
    check_eq("dma_wr_ram", ram[8'h10], 8'h3C);
    check_eq("cpu_rdata_held", cpu_rdata, 8'hA5);

    // Continuous contention: CPU x3 then DMA
    cpu_we = 0; cpu_addr = 8'h42; dma_we = 0; dma_addr = 8'h10;
    collect_acks(8, -1);
    for (int k = 0; k < 8; k++) check_eq($sformatf("order_a_%0d", k), owners[k], exp_order_a[k]);
    check_eq("dma_rdata_after_reads", dma_rdata, 8'h3C);

    // dma_req gap clears the starvation count
    collect_acks(7, 2);
    for (int k = 0; k < 7; k++) check_eq($sformatf("order_b_%0d", k), owners[k], exp_order_b[k]);

    // Reset during DATA of a CPU write
    cpu_we = 1'b1; cpu_addr = 8'h20; cpu_wdata = 8'h77; cpu_req = 1'b1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_mem_we", mem_we, 1);
    check_eq("pre_rst_mem_addr", mem_addr, 8'h20);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_mem_we", mem_we, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_mem_addr", mem_addr, 0);
    check_eq("midrst_rdata", cpu_rdata, 0);
    cpu_req = 1'b0;
    ack_after_rst = 0;
    repeat (3) begin
      @(negedge clk);
      if (cpu_ack) ack_after_rst++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (cpu_ack) ack_after_rst++;
    end
    check_eq("midrst_no_ack", ack_after_rst, 0);
    run_txn(1'b0, 1'b0, 8'h42, 8'h00, 1'b0);
    check_eq("post_rst_ack_idx", ack_idx, 2);
    check_eq("post_rst_rdata", cpu_rdata, 8'hA5);

    // cpu_req dropped during ADDR
    run_txn(1'b0, 1'b1, 8'h55, 8'h99, 1'b1);
    check_eq("drop_ack_cnt", ack_cnt, 1);
    check_eq("drop_busy_cycles", busy_cnt, 3);
    check_eq("drop_we_cycles", we_cnt, 1);
    check_eq("drop_ram", ram[8'h55], 8'h99);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
